// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin arbiter sharing one SPI master engine
//
// Purpose:
//   Grants one of NUM_REQ requesters at a time (round-robin), hands the
//   winner's 16-bit command to the SPI master with a one-cycle strobe, waits
//   for spi_done or a timeout, then returns a per-requester ack/err pulse and
//   holds an idle gap on the bus before the next grant.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   req          in   [NUM_REQ-1:0] request per requester, held until ack/err
//   req_cmd      in   [16*NUM_REQ-1:0] command of requester i at [16*i+15:16*i]
//   ack          out  [NUM_REQ-1:0] 1-cycle pulse, transaction completed
//   err          out  [NUM_REQ-1:0] 1-cycle pulse, transaction timed out
//   rsp_data     out  [15:0] read data of last completed transaction
//   busy         out  high whenever the arbiter is not idle
//   spi_wrt      out  1-cycle start strobe to the SPI master
//   spi_cmd      out  [15:0] command to the SPI master, held until next grant
//   spi_done     in   1-cycle completion pulse from the SPI master
//   spi_rd_data  in   [15:0] SPI master read data, valid with spi_done

module spi_xfer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic [15:0]            rsp_data,
  output logic                   busy,
  output logic                   spi_wrt,
  output logic [15:0]            spi_cmd,
  input  logic                   spi_done,
  input  logic [15:0]            spi_rd_data
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_err;
  logic [15:0]         r_rsp;
  logic                r_busy;
  logic                r_wrt;
  logic [15:0]         r_cmd;
  // The current grant and the round-robin pointer are always the same value,
  // so one register serves both roles.
  logic [GW-1:0]       r_last_gnt;
  logic [TW-1:0]       r_tmo;
  logic [7:0]          r_gap;

  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_ack_nxt;
  logic [NUM_REQ-1:0]  w_err_nxt;
  logic [15:0]         w_rsp_nxt;
  logic                w_wrt_nxt;
  logic [15:0]         w_cmd_nxt;
  logic [GW-1:0]       w_last_nxt;
  logic [TW-1:0]       w_tmo_nxt;
  logic [7:0]          w_gap_nxt;

  logic                w_found;
  logic [GW-1:0]       w_winner;
  logic [GW-1:0]       w_idx;
  logic [15:0]         w_win_cmd;

  // Round-robin search: first active request at or after last_gnt+1, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_last_gnt) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) begin
        w_win_cmd = req_cmd[16*i +: 16];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_rsp_nxt   = r_rsp;
    w_wrt_nxt   = 1'b0;
    w_cmd_nxt   = r_cmd;
    w_last_nxt  = r_last_gnt;
    w_tmo_nxt   = r_tmo;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_last_nxt  = w_winner;
          w_cmd_nxt   = w_win_cmd;
          w_wrt_nxt   = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_tmo_nxt = r_tmo + 1'b1;
        // A done arriving on the final timeout cycle still counts as success.
        if (spi_done) begin
          w_rsp_nxt             = spi_rd_data;
          w_ack_nxt[r_last_gnt] = 1'b1;
          w_gap_nxt             = 8'(GAP_CYCLES);
          w_state_nxt           = S_GAP;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_err_nxt[r_last_gnt] = 1'b1;
          w_gap_nxt             = 8'(GAP_CYCLES);
          w_state_nxt           = S_GAP;
        end
      end
      S_GAP: begin
        // Ack/err cycle is the first GAP cycle, giving the requester time to
        // drop req before IDLE samples it again.
        if (r_gap == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_err      <= '0;
      r_rsp      <= '0;
      r_busy     <= 1'b0;
      r_wrt      <= 1'b0;
      r_cmd      <= '0;
      r_last_gnt <= GW'(NUM_REQ - 1);
      r_tmo      <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rsp      <= w_rsp_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_wrt      <= w_wrt_nxt;
      r_cmd      <= w_cmd_nxt;
      r_last_gnt <= w_last_nxt;
      r_tmo      <= w_tmo_nxt;
      r_gap      <= w_gap_nxt;
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign rsp_data = r_rsp;
  assign busy     = r_busy;
  assign spi_wrt  = r_wrt;
  assign spi_cmd  = r_cmd;

endmodule
